core_mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Takes the execute-stage result (address or ALU value), store data and load/store type, and runs a req/ack transaction on the data bus.
- Aligns and extends load data, generates byte enables for stores, and stalls upstream stages while the bus is busy.
- Registers the stage result for writeback.

---
 rtl/core_mem_access_pkg.sv | 38 +++
 rtl/mem_align.sv | 53 +++++
 rtl/core_mem_access.sv | 187 ++++++++++++++++++
 tb/tb_core_mem_access.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_access_pkg.sv
// Shared types for the memory-access stage: access types, FSM states and
// natural-alignment helpers used by the address path.
package core_mem_access_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        BYTE  = 3'd1,
        HALF  = 3'd2,
        WORD  = 3'd3,
        DWORD = 3'd4
    } mem_type_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Offset bits that must be zero for the access type's natural alignment.
    function automatic logic [2:0] align_mask(input mem_type_t t);
        logic [2:0] m;
        case (t)
            HALF:    m = 3'b001;
            WORD:    m = 3'b011;
            DWORD:   m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input mem_type_t t, input logic [2:0] a);
        return |(a & align_mask(t));
    endfunction

    function automatic logic [2:0] natural_offset(input mem_type_t t, input logic [2:0] a);
        return a & ~align_mask(t);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data bus: byte enables and replicated store data,
// plus shift/extend of returned load data. Purely combinational.
module mem_align
    import core_mem_access_pkg::*;
(
    input  logic [2:0]  addr,
    input  mem_type_t   mem_type,
    input  logic        sign_ext,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    output logic [7:0]  be,
    output logic [63:0] wdata_rep,
    output logic [63:0] load_data
);

    logic [63:0] shifted_s;

    // Select enables, replicate store bytes and extend the addressed load field.
    always_comb begin
        shifted_s = rdata >> {addr, 3'b000};
        be        = 8'h00;
        wdata_rep = 64'h0;
        load_data = 64'h0;
        case (mem_type)
            BYTE: begin
                be        = 8'h01 << addr;
                wdata_rep = {8{wdata[7:0]}};
                load_data = {{56{sign_ext & shifted_s[7]}}, shifted_s[7:0]};
            end
            HALF: begin
                be        = 8'h03 << addr;
                wdata_rep = {4{wdata[15:0]}};
                load_data = {{48{sign_ext & shifted_s[15]}}, shifted_s[15:0]};
            end
            WORD: begin
                be        = 8'h0F << addr;
                wdata_rep = {2{wdata[31:0]}};
                load_data = {{32{sign_ext & shifted_s[31]}}, shifted_s[31:0]};
            end
            DWORD: begin
                be        = 8'hFF;
                wdata_rep = wdata;
                load_data = shifted_s;
            end
            default: begin
                be        = 8'h00;
                wdata_rep = 64'h0;
                load_data = 64'h0;
            end
        endcase
    end

endmodule

// File: rtl/core_mem_access.sv
// Memory-access stage: runs one req/ack data-bus transaction per memop and
// registers the stage result. MEM_ALIGN_CHECK_EN enables misalignment traps.
module core_mem_access
    import core_mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [63:0] ex_out,
    input  logic [63:0] ex_B_data,
    input  logic [2:0]  ex_load_type,
    input  logic [2:0]  ex_store_type,
    input  logic        ex_signed,
    input  logic [4:0]  ex_W_regnum,
    input  logic        ex_write_enable,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [63:0] dbus_addr,
    output logic [7:0]  dbus_be,
    output logic [63:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [63:0] dbus_rdata,
    output logic        stall,
    output logic [63:0] mem_data,
    output logic [4:0]  mem_W_regnum,
    output logic        mem_write_enable,
    output logic        addr_error,
    output logic        bus_error
);

    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    mem_type_t   load_type_s, store_type_s, acc_type_s;
    mem_state_t  state_r, next_state_s;
    logic        is_store_s, memop_s, misaligned_s, busy_s, flush_eff_s, stall_s;
    logic [2:0]  offset_s;
    logic [7:0]  be_s;
    logic [63:0] wdata_s, load_data_s;
    logic [31:0] count_r, count_next_s;
    logic        flush_pending_r, flush_pending_next_s;
    logic [63:0] mem_data_r, mem_data_next_s;
    logic [4:0]  regnum_r, regnum_next_s;
    logic        wen_r, wen_next_s;
    logic        addr_error_r, addr_error_next_s;
    logic        bus_error_r, bus_error_next_s;

    // Decode the access; a store wins when both type fields are set.
    always_comb begin
        load_type_s  = mem_type_t'(ex_load_type);
        store_type_s = mem_type_t'(ex_store_type);
        is_store_s   = (store_type_s != NONE);
        memop_s      = is_store_s || (load_type_s != NONE);
        if (is_store_s) begin
            acc_type_s = store_type_s;
        end else begin
            acc_type_s = load_type_s;
        end
`ifdef MEM_ALIGN_CHECK_EN
        misaligned_s = is_misaligned(acc_type_s, ex_out[2:0]);
        offset_s     = ex_out[2:0];
`else
        misaligned_s = 1'b0;
        offset_s     = natural_offset(acc_type_s, ex_out[2:0]);
`endif
    end

    mem_align u_align (
        .addr      (offset_s),
        .mem_type  (acc_type_s),
        .sign_ext  (ex_signed),
        .rdata     (dbus_rdata),
        .wdata     (ex_B_data),
        .be        (be_s),
        .wdata_rep (wdata_s),
        .load_data (load_data_s)
    );

    assign busy_s      = (state_r == BUSY);
    assign flush_eff_s = flush_pending_r | flush;
    // Bus signals are only meaningful while a request is outstanding.
    assign dbus_req    = busy_s;
    assign dbus_we     = busy_s & is_store_s;
    assign dbus_addr   = busy_s ? {ex_out[63:3], 3'b000} : 64'h0;
    assign dbus_be     = busy_s ? be_s : 8'h00;
    assign dbus_wdata  = busy_s ? wdata_s : 64'h0;
    assign stall       = stall_s;

    // Next-state, stall and result-register update logic.
    always_comb begin
        next_state_s         = state_r;
        stall_s              = 1'b0;
        count_next_s         = count_r;
        flush_pending_next_s = flush_pending_r;
        mem_data_next_s      = mem_data_r;
        regnum_next_s        = regnum_r;
        wen_next_s           = wen_r;
        addr_error_next_s    = 1'b0;
        bus_error_next_s     = 1'b0;
        case (state_r)
            IDLE: begin
                count_next_s         = 32'd0;
                flush_pending_next_s = 1'b0;
                if (flush) begin
                    mem_data_next_s = 64'h0;
                    regnum_next_s   = 5'd0;
                    wen_next_s      = 1'b0;
                end else if (!memop_s) begin
                    mem_data_next_s = ex_out;
                    regnum_next_s   = ex_W_regnum;
                    wen_next_s      = ex_write_enable;
                end else if (misaligned_s) begin
                    mem_data_next_s   = 64'h0;
                    regnum_next_s     = 5'd0;
                    wen_next_s        = 1'b0;
                    addr_error_next_s = 1'b1;
                end else begin
                    stall_s      = 1'b1;
                    next_state_s = BUSY;
                end
            end
            BUSY: begin
                if (dbus_ack) begin
                    next_state_s         = IDLE;
                    count_next_s         = 32'd0;
                    flush_pending_next_s = 1'b0;
                    if (flush_eff_s) begin
                        mem_data_next_s = 64'h0;
                        regnum_next_s   = 5'd0;
                        wen_next_s      = 1'b0;
                    end else begin
                        mem_data_next_s = is_store_s ? ex_out : load_data_s;
                        regnum_next_s   = ex_W_regnum;
                        wen_next_s      = ex_write_enable;
                    end
                end else if ((TIMEOUT_CYCLES != 32'd0) && (count_r == TIMEOUT_LAST)) begin
                    // Abandon the transaction; a late ack lands in IDLE and is dropped.
                    next_state_s         = IDLE;
                    count_next_s         = 32'd0;
                    flush_pending_next_s = 1'b0;
                    mem_data_next_s      = 64'h0;
                    regnum_next_s        = 5'd0;
                    wen_next_s           = 1'b0;
                    bus_error_next_s     = 1'b1;
                end else begin
                    stall_s              = 1'b1;
                    count_next_s         = count_r + 32'd1;
                    flush_pending_next_s = flush_eff_s;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, timeout counter, flush tracking and registered stage outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            count_r         <= 32'd0;
            flush_pending_r <= 1'b0;
            mem_data_r      <= 64'h0;
            regnum_r        <= 5'd0;
            wen_r           <= 1'b0;
            addr_error_r    <= 1'b0;
            bus_error_r     <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            count_r         <= count_next_s;
            flush_pending_r <= flush_pending_next_s;
            mem_data_r      <= mem_data_next_s;
            regnum_r        <= regnum_next_s;
            wen_r           <= wen_next_s;
            addr_error_r    <= addr_error_next_s;
            bus_error_r     <= bus_error_next_s;
        end
    end

    assign mem_data         = mem_data_r;
    assign mem_W_regnum     = regnum_r;
    assign mem_write_enable = wen_r;
    assign addr_error       = addr_error_r;
    assign bus_error        = bus_error_r;

endmodule

// File: tb/tb_core_mem_access.sv
// Self-checking bench for core_mem_access: directed cases plus randomized
// transactions compared against a byte-level reference model.
module tb_core_mem_access;

    logic        clock = 1'b0;
    logic        reset, flush, ex_signed, ex_write_enable, dbus_ack, ack_to;
    logic [63:0] ex_out, ex_B_data, dbus_rdata;
    logic [2:0]  ex_load_type, ex_store_type;
    logic [4:0]  ex_W_regnum;

    logic        dbus_req, dbus_we, stall, mem_write_enable, addr_error, bus_error;
    logic [63:0] dbus_addr, dbus_wdata, mem_data;
    logic [7:0]  dbus_be;
    logic [4:0]  mem_W_regnum;

    logic        to_dbus_req, to_dbus_we, to_stall, to_mem_write_enable, to_addr_error, to_bus_error;
    logic [63:0] to_dbus_addr, to_dbus_wdata, to_mem_data;
    logic [7:0]  to_dbus_be;
    logic [4:0]  to_mem_W_regnum;

    int errors = 0;
    int checks = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    always #5 clock = ~clock;

    core_mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .flush(flush), .ex_out(ex_out), .ex_B_data(ex_B_data),
        .ex_load_type(ex_load_type), .ex_store_type(ex_store_type), .ex_signed(ex_signed),
        .ex_W_regnum(ex_W_regnum), .ex_write_enable(ex_write_enable),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .stall(stall),
        .mem_data(mem_data), .mem_W_regnum(mem_W_regnum), .mem_write_enable(mem_write_enable),
        .addr_error(addr_error), .bus_error(bus_error)
    );

    core_mem_access #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock(clock), .reset(reset), .flush(flush), .ex_out(ex_out), .ex_B_data(ex_B_data),
        .ex_load_type(ex_load_type), .ex_store_type(ex_store_type), .ex_signed(ex_signed),
        .ex_W_regnum(ex_W_regnum), .ex_write_enable(ex_write_enable),
        .dbus_req(to_dbus_req), .dbus_we(to_dbus_we), .dbus_addr(to_dbus_addr), .dbus_be(to_dbus_be),
        .dbus_wdata(to_dbus_wdata), .dbus_ack(ack_to), .dbus_rdata(dbus_rdata), .stall(to_stall),
        .mem_data(to_mem_data), .mem_W_regnum(to_mem_W_regnum), .mem_write_enable(to_mem_write_enable),
        .addr_error(to_addr_error), .bus_error(to_bus_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int type_size(input logic [2:0] t);
        case (t)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return 4;
            3'd4:    return 8;
            default: return 0;
        endcase
    endfunction

    // Gather size bytes starting at byte a, then extend from the top byte gathered.
    function automatic logic [63:0] m_load(input logic [63:0] rd, input int a, input int size, input logic sgn);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 8; i++)
            if (i < size && a + i < 8) r[8*i +: 8] = rd[8*(a+i) +: 8];
        if (sgn && size < 8 && r[8*size-1])
            for (int i = 0; i < 8; i++)
                if (i >= size) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic drive_none();
        ex_out = 64'h0; ex_B_data = 64'h0; ex_load_type = 3'd0; ex_store_type = 3'd0;
        ex_signed = 1'b0; ex_W_regnum = 5'd0; ex_write_enable = 1'b0;
        flush = 1'b0; dbus_ack = 1'b0;
    endtask

    task automatic run_plain(input logic [63:0] v, input logic [4:0] rn, input logic we, input logic fl);
        drive_none();
        ex_out = v; ex_W_regnum = rn; ex_write_enable = we; flush = fl;
        #1;
        check("plain_stall", stall, 1'b0);
        check("plain_req", dbus_req, 1'b0);
        tick();
        check("plain_data", mem_data, fl ? 64'h0 : v);
        check("plain_regnum", mem_W_regnum, fl ? 5'd0 : rn);
        check("plain_wen", mem_write_enable, fl ? 1'b0 : we);
        flush = 1'b0;
    endtask

    task automatic run_memop(input logic [63:0] addr, input logic [63:0] bdata, input logic [63:0] rdata,
                             input logic [2:0] lt, input logic [2:0] st, input logic sgn,
                             input logic [4:0] rn, input logic we, input int ack_at, input int flush_at);
        logic [2:0]  typ;
        int          size, a, a_eff;
        logic        is_st, mis, flushed;
        logic [7:0]  e_be;
        logic [63:0] e_wd, e_res;
        is_st   = (st != 3'd0);
        typ     = is_st ? st : lt;
        size    = type_size(typ);
        a       = int'(addr[2:0]);
        mis     = (a % size) != 0;
        a_eff   = CHECK_EN ? a : a - (a % size);
        flushed = (flush_at > 0);
        e_be    = 8'h00;
        e_wd    = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (i >= a_eff && i < a_eff + size) e_be[i] = 1'b1;
            e_wd[8*i +: 8] = bdata[8*(i % size) +: 8];
        end
        e_res = is_st ? addr : m_load(rdata, a_eff, size, sgn);

        ex_out = addr; ex_B_data = bdata; ex_load_type = lt; ex_store_type = st;
        ex_signed = sgn; ex_W_regnum = rn; ex_write_enable = we;
        flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = rdata;
        #1;
        if (CHECK_EN && mis) begin
            check("mis_stall", stall, 1'b0);
            check("mis_req", dbus_req, 1'b0);
            tick();
            check("mis_addr_error", addr_error, 1'b1);
            check("mis_wen", mem_write_enable, 1'b0);
            drive_none();
            #1;
            check("mis_req_after", dbus_req, 1'b0);
            tick();
            check("mis_addr_error_clear", addr_error, 1'b0);
        end else begin
            check("issue_stall", stall, 1'b1);
            check("issue_req", dbus_req, 1'b0);
            tick();
            for (int k = 1; k <= ack_at; k++) begin
                flush    = (k == flush_at);
                dbus_ack = (k == ack_at);
                #1;
                check("busy_req", dbus_req, 1'b1);
                check("busy_addr", dbus_addr, addr & ~64'h7);
                check("busy_be", dbus_be, e_be);
                check("busy_we", dbus_we, is_st);
                if (is_st) check("busy_wdata", dbus_wdata, e_wd);
                check("busy_stall", stall, k != ack_at);
                tick();
            end
            dbus_ack = 1'b0;
            flush    = 1'b0;
            check("done_data", mem_data, flushed ? 64'h0 : e_res);
            check("done_regnum", mem_W_regnum, flushed ? 5'd0 : rn);
            check("done_wen", mem_write_enable, flushed ? 1'b0 : we);
            check("done_errors", {addr_error, bus_error}, 2'b00);
            drive_none();
            #1;
            check("done_req", dbus_req, 1'b0);
            check("done_stall", stall, 1'b0);
        end
    endtask

    int          kind, ack_at, fl_at;
    logic [2:0]  t, lt, st;

    initial begin
        reset = 1'b1;
        ack_to = 1'b0;
        dbus_rdata = 64'h0;
        drive_none();
        #1;
        check("rst_data", mem_data, 64'h0);
        check("rst_wen", mem_write_enable, 1'b0);
        check("rst_req", dbus_req, 1'b0);
        check("rst_errors", {addr_error, bus_error}, 2'b00);
        tick();
        tick();
        reset = 1'b0;

        run_plain(64'h1234, 5'd3, 1'b1, 1'b0);
        run_memop(64'h1005, 64'h0, 64'h0000_8000_0000_0000, 3'd1, 3'd0, 1'b1, 5'd7, 1'b1, 4, 0);
        check("sbyte_data", mem_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_memop(64'h2004, 64'hDEADBEEF, 64'h0, 3'd0, 3'd3, 1'b0, 5'd0, 1'b0, 1, 0);
        check("wstore_wen", mem_write_enable, 1'b0);
        run_memop(64'h3001, 64'h0, 64'h1122_3344_5566_7788, 3'd2, 3'd0, 1'b0, 5'd9, 1'b1, 2, 0);
        run_memop(64'h4008, 64'h0, 64'hCAFE_F00D_1234_5678, 3'd4, 3'd0, 1'b0, 5'd10, 1'b1, 5, 2);
        run_plain(64'h55AA, 5'd1, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                run_plain({$urandom, $urandom}, 5'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
            end else begin
                t      = 3'($urandom_range(1, 4));
                ack_at = $urandom_range(1, 4);
                fl_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ack_at) : 0;
                if ($urandom_range(0, 1) == 1) begin
                    st = t;
                    lt = 3'($urandom_range(0, 4));
                end else begin
                    st = 3'd0;
                    lt = t;
                end
                run_memop({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                          lt, st, 1'($urandom), 5'($urandom), 1'($urandom), ack_at, fl_at);
            end
        end

        // Timeout on the instance whose bus never acks.
        reset = 1'b1;
        drive_none();
        tick();
        reset = 1'b0;
        tick();
        ex_load_type = 3'd3; ex_out = 64'h40; ex_W_regnum = 5'd2; ex_write_enable = 1'b1;
        #1;
        check("to_issue_stall", to_stall, 1'b1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("to_req", to_dbus_req, 1'b1);
            check("to_stall", to_stall, k < 4);
            tick();
        end
        check("to_bus_error", to_bus_error, 1'b1);
        check("to_wen", to_mem_write_enable, 1'b0);
        check("to_data", to_mem_data, 64'h0);
        drive_none();
        #1;
        check("to_req_after", to_dbus_req, 1'b0);
        tick();
        check("to_bus_error_clear", to_bus_error, 1'b0);

        // Reset in the middle of a transaction.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_plain(64'hABCD, 5'd4, 1'b1, 1'b0);
        ex_load_type = 3'd4; ex_out = 64'h80; ex_W_regnum = 5'd6; ex_write_enable = 1'b1;
        tick();
        #1;
        check("mid_req", dbus_req, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", dbus_req, 1'b0);
        check("mid_rst_we", dbus_we, 1'b0);
        check("mid_rst_be", dbus_be, 8'h00);
        check("mid_rst_data", mem_data, 64'h0);
        check("mid_rst_regnum", mem_W_regnum, 5'd0);
        check("mid_rst_wen", mem_write_enable, 1'b0);
        check("mid_rst_errors", {addr_error, bus_error}, 2'b00);
        tick();
        reset = 1'b0;
        drive_none();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
